// File: rtl/param_fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO family
// (also used by the asynchronous FIFO).
package param_fifo_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 16;

   // Bits needed to encode the values 0..value-1; returns 0 for value <= 1.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer bus of param_sync_fifo: write/read requests, data, count and status flags.
interface param_sync_fifo_if
   import param_fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int CW = clog2(DEPTH + 1);

   logic             we;
   logic [WIDTH-1:0] datain;
   logic             re;
   logic [WIDTH-1:0] dataout;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output we, datain, re,
      input  dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  we, datain, re,
      output dataout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/param_sync_fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array, synchronous write port and
// asynchronous read port.
module fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   // Contents are deliberately not reset.
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with occupancy count, threshold flags and error pulses.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads (registered read otherwise).
module param_sync_fifo
   import param_fifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2
) (
   input  logic             clk,
   input  logic             reset,
   param_sync_fifo_if.slave fifo
);
   localparam int PW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
   localparam int CW = clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

   generate
      if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
          AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_params
         $error("param_sync_fifo: illegal DEPTH / AF_LEVEL / AE_LEVEL combination");
      end
   endgenerate

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      return (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
   endfunction

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             full, empty, rd_ok, wr_ok;
   logic [WIDTH-1:0] rd_data;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);
   assign rd_ok = fifo.re && !empty;
   // A write at full only fits if the head is popped in the same cycle.
   assign wr_ok = fifo.we && (!full || rd_ok);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = fifo.we && !wr_ok;
      underflow_d = fifo.re && !rd_ok;
      if (wr_ok) wr_ptr_d = next_ptr(wr_ptr_q);
      if (rd_ok) rd_ptr_d = next_ptr(rd_ptr_q);
      if (wr_ok && !rd_ok) begin
         count_d = count_q + CW'(1);
      end else if (rd_ok && !wr_ok) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (PW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr_q),
      .wr_data (fifo.datain),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
   // Head word is presented as soon as it exists; re only pops it.
   assign fifo.dataout = empty ? '0 : rd_data;
`else
   logic [WIDTH-1:0] dataout_q, dataout_d;

   always_comb begin
      dataout_d = dataout_q;
      if (rd_ok) dataout_d = rd_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dataout_q <= '0;
      end else begin
         dataout_q <= dataout_d;
      end
   end

   assign fifo.dataout = dataout_q;
`endif

   assign fifo.count        = count_q;
   assign fifo.full         = full;
   assign fifo.empty        = empty;
   assign fifo.almost_full  = (count_q >= CNT_AF);
   assign fifo.almost_empty = (count_q <= CNT_AE);
   assign fifo.overflow     = overflow_q;
   assign fifo.underflow    = underflow_q;

endmodule
